// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq
// Description : Reset sequencer. Debounces an external push-button reset,
//               merges it with software and watchdog requests, holds all
//               stage resets low for HOLD_CYC cycles, then releases
//               o_rstn_out[0], [1] and [2] in order, GAP_CYC cycles apart.
//               A final GAP_CYC settle interval follows the last release.
//               At the end of that interval, o_rst_busy drops and o_rst_done
//               pulses for one cycle.
// Ports       : clk          - single clock, rising edge
//               rst          - synchronous active-high reset
//               i_btn_rstn   - push-button reset, async to clk, active-low
//               i_sw_req     - software reset request, one-cycle pulse
//               i_wdt_req    - watchdog reset request, one-cycle pulse
//               o_rstn_out   - active-low stage resets (bit0 released first)
//               o_rst_busy   - high while the sequence is in progress
//               o_rst_done   - one-cycle pulse when the sequence completes
//               o_rst_cause  - 00 power-on, 01 button, 10 software, 11 watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq #(
    parameter int DB_CYC   = 16,
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_rstn,
    input  logic       i_sw_req,
    input  logic       i_wdt_req,
    output logic [2:0] o_rstn_out,
    output logic       o_rst_busy,
    output logic       o_rst_done,
    output logic [1:0] o_rst_cause
);

    localparam int c_db_w   = (DB_CYC   > 1) ? $clog2(DB_CYC)   : 1;
    localparam int c_hold_w = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int c_gap_w  = (GAP_CYC  > 1) ? $clog2(GAP_CYC)  : 1;

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DB_CYC - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYC - 1);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_STG0 = 3'd1,
        S_STG1 = 3'd2,
        S_STG2 = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic              r_sync1;
    logic              r_sync2;
    logic              r_btn_stable;
    logic [c_db_w-1:0] r_db_cnt;
    logic              w_disagree;
    logic              w_db_take;
    logic              w_btn_fall;

    assign w_disagree = (r_sync2 != r_btn_stable);
    assign w_db_take  = w_disagree && (r_db_cnt == c_db_last);
    // Trigger fires on the same edge btn_stable falls, so the sequence
    // starts without an extra cycle of edge-detect latency.
    assign w_btn_fall = w_db_take && !r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_btn_stable <= 1'b1;
            r_db_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn_rstn;
            r_sync2 <= r_sync1;
            if (!w_disagree) begin
                r_db_cnt <= '0;
            end else if (w_db_take) begin
                r_btn_stable <= r_sync2;
                r_db_cnt     <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [2:0]          r_rstn;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_cause;

    state_t              w_state_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [c_gap_w-1:0]  w_gap_nxt;
    logic [2:0]          w_rstn_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [1:0]          w_cause_nxt;
    logic                w_trig;

    assign w_trig = w_btn_fall | i_sw_req | i_wdt_req;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_cause_nxt = r_cause;

        if (w_trig) begin
            // A trigger restarts from HOLD regardless of the current state.
            w_state_nxt = S_HOLD;
            w_hold_nxt  = '0;
            w_gap_nxt   = '0;
            if (w_btn_fall) begin
                w_cause_nxt = 2'b01;
            end else if (i_wdt_req) begin
                w_cause_nxt = 2'b11;
            end else begin
                w_cause_nxt = 2'b10;
            end
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        // Counter saturates while the button is still down.
                        if (r_btn_stable) begin
                            w_state_nxt = S_STG0;
                            w_hold_nxt  = '0;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
                S_STG0, S_STG1, S_STG2: begin
                    if (r_gap_cnt == c_gap_last) begin
                        w_gap_nxt = '0;
                        case (r_state)
                            S_STG0:  w_state_nxt = S_STG1;
                            S_STG1:  w_state_nxt = S_STG2;
                            default: w_state_nxt = S_RUN;
                        endcase
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered, so each
        // stage release is a clean single flop transition.
        case (w_state_nxt)
            S_HOLD:  w_rstn_nxt = 3'b000;
            S_STG0:  w_rstn_nxt = 3'b001;
            S_STG1:  w_rstn_nxt = 3'b011;
            default: w_rstn_nxt = 3'b111;
        endcase
        w_busy_nxt = (w_state_nxt != S_RUN);
        w_done_nxt = (r_state == S_STG2) && (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_rstn     <= 3'b000;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_cause    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_rstn     <= w_rstn_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    assign o_rstn_out  = r_rstn;
    assign o_rst_busy  = r_busy;
    assign o_rst_done  = r_done;
    assign o_rst_cause = r_cause;

endmodule
`default_nettype wire
